// File: rtl/dcache_way_array.sv
// Set-associative data cache way array: tag/data storage, single-cycle lookup with
// byte-masked store merge, age-based LRU replacement, line fill and invalidate-all walk.
module dcache_way_array #(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned INDEX_BITS  = 3,
    parameter int unsigned OFFSET_BITS = 4,
    parameter int unsigned ADDR_BITS   = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [ADDR_BITS-1:0]                          req_addr,
    input  logic                                          req_write,
    input  logic [15:0]                                   req_wdata,
    input  logic [1:0]                                    req_wmask,
    output logic                                          resp_valid,
    output logic                                          resp_hit,
    output logic [15:0]                                   resp_rdata,
    output logic                                          victim_valid,
    output logic                                          victim_dirty,
    output logic [ADDR_BITS-INDEX_BITS-OFFSET_BITS-1:0]   victim_tag,
    output logic [8*(2**OFFSET_BITS)-1:0]                 victim_data,
    input  logic                                          fill_valid,
    input  logic [ADDR_BITS-1:0]                          fill_addr,
    input  logic [8*(2**OFFSET_BITS)-1:0]                 fill_data,
    input  logic                                          flush_start,
    output logic                                          flush_busy,
    output logic                                          flush_done
);

    localparam int unsigned SETS          = 2 ** INDEX_BITS;
    localparam int unsigned LINE          = 8 * (2 ** OFFSET_BITS);
    localparam int unsigned TAG_BITS      = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned AGE_BITS      = $clog2(WAYS);
    localparam int unsigned LINE_IDX_BITS = OFFSET_BITS + 3;

    typedef logic [AGE_BITS-1:0] way_t;
    typedef logic [WAYS-1:0][AGE_BITS-1:0] age_vec_t;

    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_t;

    // Storage arrays
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    age_vec_t            age_q   [SETS];
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [LINE-1:0]     data_q  [SETS][WAYS];

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] cnt_q, cnt_d;

    logic                resp_valid_q, resp_hit_q, victim_valid_q, victim_dirty_q;
    logic [15:0]         resp_rdata_q;
    logic [TAG_BITS-1:0] victim_tag_q;
    logic [LINE-1:0]     victim_data_q;

    // Touched way becomes youngest; ways younger than it age by one.
    function automatic age_vec_t lru_touch(input age_vec_t ages, input way_t w);
        age_vec_t res;
        res = ages;
        for (int k = 0; k < WAYS; k++) begin
            if (way_t'(k) == w) begin
                res[k] = '0;
            end else if (ages[k] < ages[w]) begin
                res[k] = ages[k] + 1'b1;
            end
        end
        return res;
    endfunction

    // Lowest invalid way, otherwise the oldest way.
    function automatic way_t pick_victim(input logic [WAYS-1:0] v, input age_vec_t ages);
        way_t res;
        logic found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < WAYS; k++) begin
            if (!v[k] && !found) begin
                res   = way_t'(k);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int k = 0; k < WAYS; k++) begin
                if (ages[k] == way_t'(WAYS - 1)) res = way_t'(k);
            end
        end
        return res;
    endfunction

    logic [TAG_BITS-1:0]      req_tag, fill_tag;
    logic [INDEX_BITS-1:0]    req_set, fill_set;
    logic [OFFSET_BITS-2:0]   req_word;
    logic [LINE_IDX_BITS-1:0] word_base;
    logic                     req_hit, accept, write_hit, fill_en, flush_walk;
    way_t                     hit_way, vict_way, fill_way;
    logic [15:0]              hit_word, rdata_masked, merged_word;
    logic                     unused_addr_bits;

    assign req_tag   = req_addr[ADDR_BITS-1 -: TAG_BITS];
    assign req_set   = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_word  = req_addr[OFFSET_BITS-1:1];
    assign fill_tag  = fill_addr[ADDR_BITS-1 -: TAG_BITS];
    assign fill_set  = fill_addr[OFFSET_BITS +: INDEX_BITS];
    assign word_base = {req_word, 4'b0000};

    // Byte 0 of the request and the fill offset never select anything.
    assign unused_addr_bits = ^{req_addr[0], fill_addr[OFFSET_BITS-1:0]};

    assign flush_busy = (state_q != StIdle);
    assign flush_done = (state_q == StDone);
    assign flush_walk = (state_q == StWalk);
    assign req_ready  = !flush_busy && !fill_valid;
    assign accept     = req_valid && req_ready;
    assign fill_en    = fill_valid && !flush_busy;
    assign write_hit  = accept && req_hit && req_write;

    // Tag compare, victim choice and word read/merge for the request and fill paths
    always_comb begin
        req_hit = 1'b0;
        hit_way = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (valid_q[req_set][k] && (tag_q[req_set][k] == req_tag)) begin
                req_hit = 1'b1;
                hit_way = way_t'(k);
            end
        end
        vict_way     = pick_victim(valid_q[req_set], age_q[req_set]);
        fill_way     = pick_victim(valid_q[fill_set], age_q[fill_set]);
        hit_word     = data_q[req_set][hit_way][word_base +: 16];
        rdata_masked = {req_wmask[1] ? hit_word[15:8] : 8'h00,
                        req_wmask[0] ? hit_word[7:0]  : 8'h00};
        merged_word  = {req_wmask[1] ? req_wdata[15:8] : hit_word[15:8],
                        req_wmask[0] ? req_wdata[7:0]  : hit_word[7:0]};
    end

    // Response and victim registers, captured from pre-edge array state
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_rdata_q   <= '0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
            victim_tag_q   <= '0;
            victim_data_q  <= '0;
        end else begin
            resp_valid_q   <= accept;
            resp_hit_q     <= accept && req_hit;
            resp_rdata_q   <= (accept && req_hit) ? rdata_masked : 16'h0000;
            victim_valid_q <= accept && !req_hit && valid_q[req_set][vict_way];
            victim_dirty_q <= accept && !req_hit && dirty_q[req_set][vict_way];
            victim_tag_q   <= (accept && !req_hit) ? tag_q[req_set][vict_way] : '0;
            victim_data_q  <= (accept && !req_hit) ? data_q[req_set][vict_way] : '0;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_hit_q;
    assign resp_rdata   = resp_rdata_q;
    assign victim_valid = victim_valid_q;
    assign victim_dirty = victim_dirty_q;
    assign victim_tag   = victim_tag_q;
    assign victim_data  = victim_data_q;

    // Valid/dirty/age state: reset, flush walk, fill install, hit update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= way_t'(w);
            end
        end else if (flush_walk) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[cnt_q][w] <= way_t'(w);
        end else if (fill_en) begin
            valid_q[fill_set][fill_way] <= 1'b1;
            dirty_q[fill_set][fill_way] <= 1'b0;
            age_q[fill_set]             <= lru_touch(age_q[fill_set], fill_way);
        end else if (accept && req_hit) begin
            age_q[req_set] <= lru_touch(age_q[req_set], hit_way);
            if (req_write) dirty_q[req_set][hit_way] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; writes are suppressed while reset is high
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_en) begin
                data_q[fill_set][fill_way] <= fill_data;
                tag_q[fill_set][fill_way]  <= fill_tag;
            end else if (write_hit) begin
                data_q[req_set][hit_way][word_base +: 16] <= merged_word;
            end
        end
    end

    // Flush FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush FSM next state: walk every set once, then one done cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (flush_start) begin
                    state_d = StWalk;
                    cnt_d   = '0;
                end
            end
            StWalk: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INDEX_BITS'(SETS - 1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_dcache_way_array.sv
// Self-checking bench for dcache_way_array: a 2-way and a 4-way instance share stimulus.
module tb_dcache_way_array;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_write, fill_valid, flush_start;
    logic [15:0]  req_addr, req_wdata, fill_addr;
    logic [1:0]   req_wmask;
    logic [127:0] fill_data;

    logic         u2_req_ready, u2_resp_valid, u2_resp_hit, u2_victim_valid, u2_victim_dirty;
    logic         u2_flush_busy, u2_flush_done;
    logic [15:0]  u2_resp_rdata;
    logic [8:0]   u2_victim_tag;
    logic [127:0] u2_victim_data;

    logic         u4_req_ready, u4_resp_valid, u4_resp_hit, u4_victim_valid, u4_victim_dirty;
    logic         u4_flush_busy, u4_flush_done;
    logic [15:0]  u4_resp_rdata;
    logic [8:0]   u4_victim_tag;
    logic [127:0] u4_victim_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_way_array #(.WAYS(2), .INDEX_BITS(3), .OFFSET_BITS(4), .ADDR_BITS(16)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(u2_req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(u2_resp_valid), .resp_hit(u2_resp_hit), .resp_rdata(u2_resp_rdata),
        .victim_valid(u2_victim_valid), .victim_dirty(u2_victim_dirty),
        .victim_tag(u2_victim_tag), .victim_data(u2_victim_data),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .flush_start(flush_start), .flush_busy(u2_flush_busy), .flush_done(u2_flush_done)
    );

    dcache_way_array #(.WAYS(4), .INDEX_BITS(3), .OFFSET_BITS(4), .ADDR_BITS(16)) u_dut4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(u4_req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(u4_resp_valid), .resp_hit(u4_resp_hit), .resp_rdata(u4_resp_rdata),
        .victim_valid(u4_victim_valid), .victim_dirty(u4_victim_dirty),
        .victim_tag(u4_victim_tag), .victim_data(u4_victim_data),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .flush_start(flush_start), .flush_busy(u4_flush_busy), .flush_done(u4_flush_done)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [1:0]  m;
        logic        hit;
        logic [15:0] rd;
        logic        vv;
        logic        vd;
        logic [8:0]  vt;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Word k of the line is base+k.
    function automatic logic [127:0] mk_line(input logic [15:0] base);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[k*16 +: 16] = base + 16'(k);
        return l;
    endfunction

    // Called at posedge+1 with the DUT ready; returns at posedge+1 after acceptance.
    task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [1:0] m);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_wmask = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic do_fill(input logic [15:0] a, input logic [127:0] d);
        fill_valid = 1'b1;
        fill_addr  = a;
        fill_data  = d;
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
    endtask

    task automatic chk2(input string n, input logic h, input logic [15:0] rd,
                        input logic vv, input logic vd, input logic [8:0] vt);
        chk({n, "_rvalid"}, u2_resp_valid, 1'b1);
        chk({n, "_hit"}, u2_resp_hit, h);
        chk({n, "_rdata"}, u2_resp_rdata, rd);
        chk({n, "_vvalid"}, u2_victim_valid, vv);
        chk({n, "_vdirty"}, u2_victim_dirty, vd);
        if (vv || h) chk({n, "_vtag"}, u2_victim_tag, vt);
    endtask

    task automatic chk4(input string n, input logic h, input logic [15:0] rd,
                        input logic vv, input logic [8:0] vt);
        chk({n, "_rvalid"}, u4_resp_valid, 1'b1);
        chk({n, "_hit"}, u4_resp_hit, h);
        chk({n, "_rdata"}, u4_resp_rdata, rd);
        chk({n, "_vvalid"}, u4_victim_valid, vv);
        if (vv) chk({n, "_vtag"}, u4_victim_tag, vt);
    endtask

    initial begin
        logic [127:0] line_a;
        int busy_cyc, done_cnt, ready_bad;

        reset = 1'b1;  req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; fill_valid = 1'b0; fill_addr = '0;
        fill_data = '0; flush_start = 1'b0;

        // fields: wr, addr, wdata, mask, hit, rdata, vvalid, vdirty, vtag
        vecs[0]  = '{1'b0, 16'h1234, 16'h0000, 2'b11, 1'b1, 16'hBEEF, 1'b0, 1'b0, 9'h0};
        vecs[1]  = '{1'b0, 16'h1234, 16'h0000, 2'b01, 1'b1, 16'h00EF, 1'b0, 1'b0, 9'h0};
        vecs[2]  = '{1'b0, 16'h1235, 16'h0000, 2'b11, 1'b1, 16'hBEEF, 1'b0, 1'b0, 9'h0};
        vecs[3]  = '{1'b0, 16'h1234, 16'h0000, 2'b10, 1'b1, 16'hBE00, 1'b0, 1'b0, 9'h0};
        vecs[4]  = '{1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b0, 9'h0};
        vecs[5]  = '{1'b0, 16'h1236, 16'h0000, 2'b11, 1'b1, 16'h1003, 1'b0, 1'b0, 9'h0};
        vecs[6]  = '{1'b0, 16'h1230, 16'h0000, 2'b11, 1'b1, 16'h1000, 1'b0, 1'b0, 9'h0};
        vecs[7]  = '{1'b1, 16'h1234, 16'hA5A5, 2'b10, 1'b1, 16'hBE00, 1'b0, 1'b0, 9'h0};
        vecs[8]  = '{1'b0, 16'h1234, 16'h0000, 2'b11, 1'b1, 16'hA5EF, 1'b0, 1'b0, 9'h0};
        vecs[9]  = '{1'b1, 16'h12B4, 16'hFFFF, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0};
        vecs[10] = '{1'b0, 16'h12B4, 16'h0000, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0};
        vecs[11] = '{1'b0, 16'h1244, 16'h0000, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_ready", u2_req_ready, 1'b1);
        chk("rst_rvalid", u2_resp_valid, 1'b0);
        chk("rst_vvalid", u2_victim_valid, 1'b0);
        chk("rst_busy", u2_flush_busy, 1'b0);
        chk("rst_done", u2_flush_done, 1'b0);

        // Cold miss, single-cycle response strobe
        do_req(1'b0, 16'h1234, 16'h0000, 2'b11);
        chk2("cold", 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0);
        @(posedge clk);
        #1;
        chk("cold_rvalid_drop", u2_resp_valid, 1'b0);

        line_a = mk_line(16'h1000);
        line_a[47:32] = 16'hBEEF;
        do_fill(16'h1230, line_a);

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].m);
            chk2($sformatf("vec%0d", i), vecs[i].hit, vecs[i].rd, vecs[i].vv, vecs[i].vd,
                 vecs[i].vt);
        end

        // 2-way LRU and dirty eviction: A=tag 24 (dirty, way0), B=tag 25, C=tag 26
        do_fill(16'h12B0, mk_line(16'h2500));
        do_req(1'b0, 16'h1334, 16'h0000, 2'b11);
        chk2("evict_dirty", 1'b0, 16'h0000, 1'b1, 1'b1, 9'h024);
        chk("evict_data_w2", u2_victim_data[47:32], 16'hA5EF);
        do_req(1'b0, 16'h1230, 16'h0000, 2'b11);
        chk2("read_a", 1'b1, 16'h1000, 1'b0, 1'b0, 9'h0);
        do_fill(16'h1330, mk_line(16'h2600));
        do_req(1'b0, 16'h12B0, 16'h0000, 2'b11);
        chk2("b_gone", 1'b0, 16'h0000, 1'b1, 1'b1, 9'h024);
        do_req(1'b0, 16'h1230, 16'h0000, 2'b11);
        chk2("a_kept", 1'b1, 16'h1000, 1'b0, 1'b0, 9'h0);
        do_req(1'b0, 16'h1332, 16'h0000, 2'b11);
        chk2("c_hit", 1'b1, 16'h2601, 1'b0, 1'b0, 9'h0);

        // Fill and request in the same cycle: fill wins, request dropped
        fill_valid = 1'b1; fill_addr = 16'h1440; fill_data = mk_line(16'h3000);
        req_valid = 1'b1; req_addr = 16'h1440; req_wmask = 2'b11; req_write = 1'b0;
        #1;
        chk("coll_ready", u2_req_ready, 1'b0);
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
        req_valid  = 1'b0;
        chk("coll_no_resp", u2_resp_valid, 1'b0);
        do_req(1'b0, 16'h1440, 16'h0000, 2'b11);
        chk2("coll_hit", 1'b1, 16'h3000, 1'b0, 1'b0, 9'h0);

        // Flush: busy SETS+1 cycles, one done pulse, fill during done ignored
        flush_start = 1'b1;
        @(posedge clk);
        #1;
        flush_start = 1'b0;
        busy_cyc = 0; done_cnt = 0; ready_bad = 0;
        for (int i = 0; i < 50; i++) begin
            fill_valid = 1'b0;
            if (!u2_flush_busy) break;
            busy_cyc++;
            if (u2_req_ready) ready_bad++;
            if (u2_flush_done) begin
                done_cnt++;
                fill_valid = 1'b1;
                fill_addr  = 16'h1600;
                fill_data  = mk_line(16'h4000);
            end
            @(posedge clk);
            #1;
        end
        fill_valid = 1'b0;
        chk("flush_ended", u2_flush_busy, 1'b0);
        chk("flush_busy_cycles", busy_cyc, 9);
        chk("flush_done_pulses", done_cnt, 1);
        chk("flush_ready_low", ready_bad, 0);
        do_req(1'b0, 16'h1234, 16'h0000, 2'b11);
        chk2("post_flush_a", 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0);
        do_req(1'b0, 16'h1330, 16'h0000, 2'b11);
        chk2("post_flush_c", 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0);
        do_req(1'b0, 16'h1440, 16'h0000, 2'b11);
        chk2("post_flush_coll", 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0);
        do_req(1'b0, 16'h1600, 16'h0000, 2'b11);
        chk2("flush_fill_ignored", 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0);

        // Reset aborts a walk in progress
        flush_start = 1'b1;
        @(posedge clk);
        #1;
        flush_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midflush_busy", u2_flush_busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", u2_flush_busy, 1'b0);
        chk("abort_done", u2_flush_done, 1'b0);
        chk("abort_ready", u2_req_ready, 1'b1);

        // 4-way LRU order in set 1: A..D filled, touch A then C, so B then D age out
        do_fill(16'h0090, mk_line(16'h0100));
        do_fill(16'h0110, mk_line(16'h0200));
        do_fill(16'h0190, mk_line(16'h0300));
        do_fill(16'h0210, mk_line(16'h0400));
        do_req(1'b0, 16'h0090, 16'h0000, 2'b11);
        chk4("w4_a", 1'b1, 16'h0100, 1'b0, 9'h0);
        do_req(1'b0, 16'h0190, 16'h0000, 2'b11);
        chk4("w4_c", 1'b1, 16'h0300, 1'b0, 9'h0);
        do_req(1'b0, 16'h0290, 16'h0000, 2'b11);
        chk4("w4_e_miss", 1'b0, 16'h0000, 1'b1, 9'h002);
        do_fill(16'h0290, mk_line(16'h0500));
        do_req(1'b0, 16'h0110, 16'h0000, 2'b11);
        chk4("w4_b_gone", 1'b0, 16'h0000, 1'b1, 9'h004);
        do_req(1'b0, 16'h0292, 16'h0000, 2'b11);
        chk4("w4_e_hit", 1'b1, 16'h0501, 1'b0, 9'h0);
        do_req(1'b0, 16'h0310, 16'h0000, 2'b11);
        chk4("w4_f_miss", 1'b0, 16'h0000, 1'b1, 9'h004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
